// File: rtl/bus_ram_responder_pkg.sv
// rtl/bus_ram_responder_pkg.sv - shared state encodings, lane masks and lane helper
package bus_ram_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RESPOND = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Lanes pushed past bit 3 fall off rather than wrapping into the next word.
    function automatic logic [3:0] lane_enables(input logic [3:0] mask, input logic [1:0] offset);
        logic [7:0] w_wide;
        w_wide = {4'b0000, mask} << offset;
        return w_wide[3:0];
    endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// rtl/bus_ram_responder_if.sv - request side of the shared system bus
interface bus_ram_responder_if;

    logic [31:0] addr_bus;
    logic        rd_bus;
    logic        wr_bus;
    logic [3:0]  data_mask_bus;

    modport master (output addr_bus, output rd_bus, output wr_bus, output data_mask_bus);
    modport slave  (input addr_bus, input rd_bus, input wr_bus, input data_mask_bus);

endinterface

// File: rtl/bus_ram_responder_ram_array.sv
// rtl/bus_ram_responder_ram_array.sv - single-port word RAM with byte-lane writes and registered read
module bus_ram_responder_ram_array #(
    parameter int DEPTH_BITS = 12
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [3:0]            i_we,
    input  logic [DEPTH_BITS-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [0:(1<<DEPTH_BITS)-1];

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/bus_ram_responder.sv
// rtl/bus_ram_responder.sv - windowed RAM slave with wait states and tristated completion
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int          ADDR_BITS   = 14,
    parameter int          WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    bus_ram_responder_if.slave  bus,
    inout  wire  [31:0]         data_bus,
    output wire                 fc_bus
);

    localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [3:0]             r_mask;
    logic [31:0]            r_wdata;
    logic                   r_is_write;

    logic                   w_hit;
    logic                   w_accept;
    logic                   w_ram_en;
    logic [3:0]             w_ram_we;
    logic [31:0]            w_ram_wdata;
    logic [31:0]            w_ram_rdata;
    logic [31:0]            w_rd_aligned;
    logic                   w_fc_oe;
    logic                   w_fc_val;
    logic                   w_data_oe;

    assign w_hit    = (bus.addr_bus[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign w_accept = (r_state == ST_IDLE) && (bus.rd_bus || bus.wr_bus) && w_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_mask     <= 4'd0;
            r_wdata    <= 32'd0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr     <= bus.addr_bus[ADDR_BITS-1:0];
                r_mask     <= bus.data_mask_bus;
                r_wdata    <= data_bus;
                r_is_write <= bus.wr_bus;
                r_cnt      <= WS_LOAD;
            end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_fc_oe   = 1'b0;
        w_fc_val  = 1'b0;
        w_data_oe = 1'b0;
        w_ram_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_ram_en = 1'b1;
                w_next   = ST_RESPOND;
            end
            ST_RESPOND: begin
                w_fc_oe   = 1'b1;
                w_fc_val  = 1'b1;
                w_data_oe = !r_is_write;
                if (!bus.rd_bus && !bus.wr_bus) begin
                    w_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Drive a solid low for one cycle so fc_bus falls cleanly before tristate.
                w_fc_oe = 1'b1;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_ram_we     = (w_ram_en && r_is_write) ? lane_enables(r_mask, r_addr[1:0]) : 4'b0000;
    assign w_ram_wdata  = r_wdata << {r_addr[1:0], 3'b000};
    assign w_rd_aligned = w_ram_rdata >> {r_addr[1:0], 3'b000};

    bus_ram_responder_ram_array #(
        .DEPTH_BITS (ADDR_BITS - 2)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[ADDR_BITS-1:2]),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign data_bus = w_data_oe ? w_rd_aligned : 32'hzzzz_zzzz;
    assign fc_bus   = w_fc_oe ? w_fc_val : 1'bz;

endmodule
